// File: rtl/mac_cfg_loader.sv
// rtl/mac_cfg_loader.sv - streams the mac_cluster config word into a shadow register and commits it atomically
// Holds the cluster in reset across each commit and gates its enable while a new config is loading.
module mac_cfg_loader #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_ACC_WIDTH  = 4 * MAC_MIN_WIDTH,
  parameter int WORD_WIDTH     = 32,
  parameter int RST_CYCLES     = 2,
  localparam int CFG_WIDTH     = 4 * MAC_ACC_WIDTH + MAC_CONF_WIDTH,
  localparam int NUM_WORDS     = (CFG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  input  logic                  run_req,
  output logic [CFG_WIDTH-1:0]  cfg,
  output logic                  cluster_rst,
  output logic                  cluster_en,
  output logic                  busy,
  output logic                  done
);

  localparam int SHADOW_W = NUM_WORDS * WORD_WIDTH;
  localparam int CNT_W    = $clog2(NUM_WORDS + 1);
  localparam int RC_W     = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_APPLY,
    S_RUN
  } state_t;

  state_t              state, state_d;
  logic [SHADOW_W-1:0] shadow, shadow_d, assembled;
  logic [CFG_WIDTH-1:0] cfg_d;
  logic [CNT_W-1:0]    count, count_d;
  logic [RC_W-1:0]     rst_cnt, rst_cnt_d;
  logic                configured, configured_d;

  assign word_ready = (state == S_LOAD);
  assign busy       = (state == S_LOAD) || (state == S_APPLY);
  assign cluster_en = (state == S_RUN) && run_req;

  always_comb begin
    state_d      = state;
    shadow_d     = shadow;
    cfg_d        = cfg;
    count_d      = count;
    rst_cnt_d    = rst_cnt;
    configured_d = configured;

    // Shadow image with the current word dropped into its slot; used both for
    // the shadow update and, on the last word, for the commit itself.
    assembled = shadow;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (count == CNT_W'(k)) begin
        assembled[k*WORD_WIDTH +: WORD_WIDTH] = word_in;
      end
    end

    case (state)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_LOAD: begin
        // A restart wins over any transfer in the same cycle, including the last word.
        if (load_start) begin
          count_d = '0;
        end else if (word_valid) begin
          shadow_d = assembled;
          if (count == CNT_W'(NUM_WORDS - 1)) begin
            state_d   = S_APPLY;
            cfg_d     = assembled[CFG_WIDTH-1:0];
            count_d   = '0;
            rst_cnt_d = '0;
          end else begin
            count_d = count + CNT_W'(1);
          end
        end
      end
      S_APPLY: begin
        if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
          state_d      = S_RUN;
          configured_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt + RC_W'(1);
        end
      end
      S_RUN: begin
        if (load_start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      shadow      <= '0;
      cfg         <= '0;
      count       <= '0;
      rst_cnt     <= '0;
      configured  <= 1'b0;
      cluster_rst <= 1'b1;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      shadow      <= shadow_d;
      cfg         <= cfg_d;
      count       <= count_d;
      rst_cnt     <= rst_cnt_d;
      configured  <= configured_d;
      // Registered from next state so the reset window lines up exactly with APPLY.
      cluster_rst <= (state_d == S_APPLY) || ((state_d != S_RUN) && !configured_d);
      done        <= (state == S_APPLY) && (state_d == S_RUN);
    end
  end

endmodule

// File: tb/tb_mac_cfg_loader.sv
// tb/tb_mac_cfg_loader.sv - scoreboard bench for mac_cfg_loader
module tb_mac_cfg_loader;

  localparam int CW = 132;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic [31:0]   word_in = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          run_req = 1'b1;
  logic [CW-1:0] cfg;
  logic          cluster_rst;
  logic          cluster_en;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int apply_rst_cnt = 0;
  logic [CW-1:0] exp_q[$];

  mac_cfg_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .run_req    (run_req),
    .cfg        (cfg),
    .cluster_rst(cluster_rst),
    .cluster_en (cluster_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    word_valid = 1'b1;
    word_in    = w;
    step();
    word_valid = 1'b0;
  endtask

  // Monitor: every done pulse pops one expected commit and checks the reset window before it.
  always @(negedge clk) begin
    if (rst) begin
      apply_rst_cnt = 0;
    end else begin
      if (busy === 1'b1 && word_ready === 1'b0 && cluster_rst === 1'b1) apply_rst_cnt++;
      if (done === 1'b1) begin
        n_done++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("commit_cfg", cfg, exp_q.pop_front());
          chk("apply_rst_cycles", apply_rst_cnt, 2);
          chk("run_rst_low", cluster_rst, 0);
        end
        apply_rst_cnt = 0;
      end
    end
  end

  logic [31:0]   wa[5] = '{32'h0000000D, 32'h11111111, 32'h22222222, 32'h33333333, 32'hFFFFFFF5};
  logic [31:0]   wb[5] = '{32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0000000C};
  logic [31:0]   wc[5] = '{32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D, 32'h0000000E};
  logic          bub[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [CW-1:0] cfg_a = {4'h5, 32'h33333333, 32'h22222222, 32'h11111111, 32'h0000000D};
  logic [CW-1:0] cfg_b = {4'hC, 32'hCAFEF00D, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
  logic [CW-1:0] cfg_c = {4'hE, 32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A};

  initial begin
    // 1 reset
    rst = 1'b1;
    run_req = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_cfg", cfg, 0);
    chk("rst_cluster_rst", cluster_rst, 1);
    chk("rst_en", cluster_en, 0);
    chk("rst_ready", word_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("idle_cluster_rst", cluster_rst, 1);
    chk("idle_busy", busy, 0);
    chk("idle_en", cluster_en, 0);

    // 2 streaming load with exact commit timing
    step();
    pulse_load();
    exp_q.push_back(cfg_a);
    for (int i = 0; i < 5; i++) begin
      word_valid = 1'b1;
      word_in = wa[i];
      step();
    end
    word_valid = 1'b0;
    @(negedge clk);
    chk("apply1_cfg", cfg, cfg_a);
    chk("apply1_rst", cluster_rst, 1);
    chk("apply1_done", done, 0);
    chk("apply1_busy", busy, 1);
    step();
    @(negedge clk);
    chk("apply2_rst", cluster_rst, 1);
    chk("apply2_done", done, 0);
    step();
    @(negedge clk);
    chk("run_done", done, 1);
    chk("run_en", cluster_en, 1);
    run_req = 1'b0;
    step();
    @(negedge clk);
    chk("run_done_once", done, 0);
    chk("run_en_follow", cluster_en, 0);
    run_req = 1'b1;

    // 3 bubbles
    pulse_load();
    exp_q.push_back(cfg_a);
    begin
      int idx = 0;
      for (int p = 0; p < 9; p++) begin
        word_valid = bub[p];
        word_in = wa[idx];
        if (p == 8) begin
          @(negedge clk);
          chk("bubble_no_commit_busy", busy, 1);
          chk("bubble_no_commit_ready", word_ready, 1);
          chk("bubble_no_done", done, 0);
        end
        step();
        if (bub[p]) idx++;
      end
    end
    word_valid = 1'b0;
    repeat (4) step();

    // 4 reload while running
    @(negedge clk);
    chk("reload_en_before", cluster_en, 1);
    pulse_load();
    @(negedge clk);
    chk("reload_en_off", cluster_en, 0);
    exp_q.push_back(cfg_b);
    for (int i = 0; i < 5; i++) begin
      send(wb[i]);
      @(negedge clk);
      chk(i < 4 ? "reload_cfg_hold" : "reload_cfg_new", cfg, i < 4 ? cfg_a : cfg_b);
    end
    repeat (4) step();

    // 5 restart, including a restart that collides with the last word
    pulse_load();
    send(32'h00000055);
    send(32'h00000066);
    load_start = 1'b1;
    send(32'h00000077);
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) send(wc[i]);
    load_start = 1'b1;
    send(wc[4]);
    load_start = 1'b0;
    @(negedge clk);
    chk("restart_last_busy", busy, 1);
    chk("restart_last_ready", word_ready, 1);
    chk("restart_cfg_hold", cfg, cfg_b);
    exp_q.push_back(cfg_c);
    for (int i = 0; i < 5; i++) send(wc[i]);
    repeat (4) step();
    @(negedge clk);
    chk("restart_cfg", cfg, cfg_c);

    // 6 abort mid-load
    pulse_load();
    for (int i = 0; i < 3; i++) send(wa[i]);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("abort_cfg", cfg, 0);
    chk("abort_cluster_rst", cluster_rst, 1);
    chk("abort_en", cluster_en, 0);
    chk("abort_ready", word_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    step();
    rst = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("abort_idle_cfg", cfg, 0);
    chk("abort_idle_busy", busy, 0);

    chk("done_count", n_done, 4);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
